divu_seq: RTL and testbench

DIVU_SEQ -- requirements
Module: divu_seq

---
 rtl/divu_seq.sv | 122 ++++++++++++
 tb/tb_divu_seq.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/divu_seq.sv
// Sequential unsigned divider: one restoring shift-subtract step per clock.
// Results land in held output registers with a one-cycle done pulse.
module divu_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] dataA,
  input  logic [WIDTH-1:0] dataB,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  // state  | meaning
  // S_IDLE | waiting for start
  // S_RUN  | WIDTH shift-subtract steps
  // S_DONE | publish results, may accept a new start
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);

  logic [1:0]       state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] div_q, div_d;
  logic [WIDTH-1:0] quo_out_q, quo_out_d;
  logic [WIDTH-1:0] rem_out_q, rem_out_d;
  logic             dbz_q, dbz_d;
  logic             done_q, done_d;

  logic [WIDTH:0] shifted;
  logic [WIDTH:0] diff;
  logic           ge;

  // The borrow out of the WIDTH+1-bit subtract doubles as the compare result.
  assign shifted = {rem_q, quo_q[WIDTH-1]};
  assign diff    = shifted - {1'b0, div_q};
  assign ge      = ~diff[WIDTH];

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    rem_d     = rem_q;
    quo_d     = quo_q;
    div_d     = div_q;
    quo_out_d = quo_out_q;
    rem_out_d = rem_out_q;
    dbz_d     = dbz_q;
    done_d    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          quo_d   = dataA;
          div_d   = dataB;
          rem_d   = '0;
          cnt_d   = '0;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        rem_d = ge ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
        quo_d = {quo_q[WIDTH-2:0], ge};
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST_STEP) state_d = S_DONE;
      end
      S_DONE: begin
        quo_out_d = quo_q;
        rem_out_d = rem_q;
        dbz_d     = (div_q == '0);
        done_d    = 1'b1;
        state_d   = S_IDLE;
        if (start) begin
          quo_d   = dataA;
          div_d   = dataB;
          rem_d   = '0;
          cnt_d   = '0;
          state_d = S_RUN;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      rem_q     <= '0;
      quo_q     <= '0;
      div_q     <= '0;
      quo_out_q <= '0;
      rem_out_q <= '0;
      dbz_q     <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rem_q     <= rem_d;
      quo_q     <= quo_d;
      div_q     <= div_d;
      quo_out_q <= quo_out_d;
      rem_out_q <= rem_out_d;
      dbz_q     <= dbz_d;
      done_q    <= done_d;
    end
  end

  assign busy        = (state_q == S_RUN);
  assign done        = done_q;
  assign quotient    = quo_out_q;
  assign remainder   = rem_out_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_divu_seq.sv
// Directed bench for divu_seq: vector table plus multi-cycle corner sequences.
module tb_divu_seq;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [31:0] dataA = '0;
  logic [31:0] dataB = '0;
  logic        busy, done, div_by_zero;
  logic [31:0] quotient, remainder;

  int checks = 0;
  int failures = 0;

  logic [31:0] prev_q = '0;
  logic [31:0] prev_r = '0;

  divu_seq #(.WIDTH(32)) dut (
    .clk(clk), .reset(reset), .start(start), .dataA(dataA), .dataB(dataB),
    .busy(busy), .done(done), .quotient(quotient), .remainder(remainder),
    .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] q;
    logic [31:0] r;
    logic        dbz;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Launch a division and wait (bounded) for done. Outputs must hold the
  // previously expected results until done; optionally scramble inputs.
  task automatic do_div(input logic [31:0] a, input logic [31:0] b, input bit scramble,
                        output int lat, output int busy_cnt, output bit hold_ok);
    start = 1'b1; dataA = a; dataB = b;
    @(posedge clk); #1;
    start = 1'b0;
    lat = 0; busy_cnt = 0; hold_ok = 1'b1;
    while (!done && lat < 100) begin
      if (busy) busy_cnt++;
      if (quotient !== prev_q || remainder !== prev_r) hold_ok = 1'b0;
      if (scramble) begin
        dataA = $urandom; dataB = $urandom;
        start = (lat == 10) ? 1'b1 : 1'b0;
      end
      @(posedge clk); #1;
      lat++;
    end
    start = 1'b0;
  endtask

  task automatic check_result(input string tag, input vec_t v, input int lat,
                              input int busy_cnt, input bit hold_ok);
    chk({tag, " latency"}, 64'(lat), 64'd33);
    chk({tag, " busy_cycles"}, 64'(busy_cnt), 64'd32);
    chk({tag, " hold_before_done"}, 64'(hold_ok), 64'd1);
    chk({tag, " quotient"}, 64'(quotient), 64'(v.q));
    chk({tag, " remainder"}, 64'(remainder), 64'(v.r));
    chk({tag, " div_by_zero"}, 64'(div_by_zero), 64'(v.dbz));
    prev_q = v.q;
    prev_r = v.r;
  endtask

  // After a done pulse: done must drop and results must stay put.
  task automatic check_after(input string tag, input vec_t v);
    bit ok;
    ok = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      if (done !== 1'b0 || busy !== 1'b0 || quotient !== v.q ||
          remainder !== v.r || div_by_zero !== v.dbz) ok = 1'b0;
    end
    chk({tag, " post_done_stable"}, 64'(ok), 64'd1);
  endtask

  initial begin
    int  lat, bc, extra_done;
    bit  hold_ok, ok;
    vec_t v, v2;

    vecs[0] = '{32'd100,        32'd7,          32'd14,         32'd2,          1'b0};
    vecs[1] = '{32'hFFFFFFFF,   32'd1,          32'hFFFFFFFF,   32'd0,          1'b0};
    vecs[2] = '{32'd3,          32'd10,         32'd0,          32'd3,          1'b0};
    vecs[3] = '{32'd5,          32'd0,          32'hFFFFFFFF,   32'd5,          1'b1};
    vecs[4] = '{32'd50,         32'd5,          32'd10,         32'd0,          1'b0};
    vecs[5] = '{32'd81,         32'd9,          32'd9,          32'd0,          1'b0};
    vecs[6] = '{32'd0,          32'd0,          32'hFFFFFFFF,   32'd0,          1'b1};
    vecs[7] = '{32'hFFFFFFFF,   32'hFFFFFFFF,   32'd1,          32'd0,          1'b0};
    vecs[8] = '{32'h80000000,   32'd3,          32'h2AAAAAAA,   32'd2,          1'b0};
    vecs[9] = '{32'd1000,       32'd1000,       32'd1,          32'd0,          1'b0};

    // Reset with start held: nothing may launch.
    start = 1'b1; dataA = 32'd100; dataB = 32'd7;
    repeat (3) @(posedge clk);
    #1;
    chk("reset busy", 64'(busy), 64'd0);
    chk("reset done", 64'(done), 64'd0);
    chk("reset quotient", 64'(quotient), 64'd0);
    chk("reset remainder", 64'(remainder), 64'd0);
    chk("reset div_by_zero", 64'(div_by_zero), 64'd0);
    start = 1'b0;
    reset = 1'b1;
    @(posedge clk); #1;
    chk("idle after reset busy", 64'(busy), 64'd0);

    for (int i = 0; i < 10; i++) begin
      do_div(vecs[i].a, vecs[i].b, 1'b0, lat, bc, hold_ok);
      check_result($sformatf("vec%0d", i), vecs[i], lat, bc, hold_ok);
      check_after($sformatf("vec%0d", i), vecs[i]);
    end

    // Start and operand changes while busy must not disturb the division.
    v = vecs[0];
    do_div(v.a, v.b, 1'b1, lat, bc, hold_ok);
    check_result("busy_ignore", v, lat, bc, hold_ok);
    check_after("busy_ignore", v);

    // Reset mid-run: immediate clear, no done, then normal operation.
    start = 1'b1; dataA = 32'd100; dataB = 32'd7;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (14) @(posedge clk);
    #2;
    reset = 1'b0;
    #1;
    chk("midrun_reset busy", 64'(busy), 64'd0);
    chk("midrun_reset quotient", 64'(quotient), 64'd0);
    chk("midrun_reset remainder", 64'(remainder), 64'd0);
    chk("midrun_reset div_by_zero", 64'(div_by_zero), 64'd0);
    @(posedge clk); #1;
    reset = 1'b1;
    prev_q = '0; prev_r = '0;
    extra_done = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (done) extra_done++;
    end
    chk("midrun_reset no_done", 64'(extra_done), 64'd0);
    v = vecs[4];
    do_div(v.a, v.b, 1'b0, lat, bc, hold_ok);
    check_result("after_reset", v, lat, bc, hold_ok);
    check_after("after_reset", v);

    // Back-to-back: second start presented in the done cycle.
    v = vecs[0];
    v2 = vecs[5];
    do_div(v.a, v.b, 1'b0, lat, bc, hold_ok);
    check_result("b2b first", v, lat, bc, hold_ok);
    do_div(v2.a, v2.b, 1'b0, lat, bc, hold_ok);
    check_result("b2b second", v2, lat, bc, hold_ok);
    check_after("b2b second", v2);

    // Idle with start low: outputs hold indefinitely.
    ok = 1'b1;
    for (int i = 0; i < 10; i++) begin
      dataA = $urandom; dataB = $urandom;
      @(posedge clk); #1;
      if (busy || done || quotient !== v2.q || remainder !== v2.r) ok = 1'b0;
    end
    chk("idle hold", 64'(ok), 64'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
